// File: rtl/instr_encoder.sv
// RV32I I/S/B instruction packer with range check, NOP substitution,
// one output register stage and an auto-incrementing word address.
module instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        imm_src,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              addr_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              out_err,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        err_count
);

    localparam logic [31:0]       NOP  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ecnt_q, ecnt_d;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic        fits12, fits13;
    logic        accept, xfer;

    assign fits12 = (&imm[31:11]) || (~|imm[31:11]);
    assign fits13 = (&imm[31:12]) || (~|imm[31:12]);

    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b1;
        unique case (imm_src)
            2'b00: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err   = !fits12;
            end
            2'b01: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3,
                             imm[4:0], opcode};
                enc_err   = !fits12;
            end
            2'b10: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                             imm[4:1], imm[11], opcode};
                enc_err   = !fits13 || imm[0];
            end
            default: begin
                enc_instr = NOP;
                enc_err   = 1'b1;
            end
        endcase
        if (enc_err) begin
            enc_instr = NOP;
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer     = valid_q && out_ready;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        ecnt_d  = ecnt_q;
        if (accept) begin
            valid_d = 1'b1;
            instr_d = enc_instr;
            err_d   = enc_err;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
        // clear takes priority over the post-transfer increment
        if (addr_clear) begin
            addr_d = BASE;
        end else if (xfer) begin
            addr_d = addr_q + 1'b1;
        end
        if (xfer && err_q && (ecnt_q != 8'hFF)) begin
            ecnt_d = ecnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
            addr_q  <= BASE;
            ecnt_q  <= 8'h0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_addr  = addr_q;
    assign err_count = ecnt_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the decode-stage immediate extender: packs register fields and a 32-bit signed immediate into an RV32I I-, S- or B-type instruction word.
- Used by the debug/program-load path to stream encoded instructions into instruction memory.
- Range-checks each immediate, substitutes a NOP on error, and stamps each accepted output with an auto-incrementing word address.
- Valid/ready on both sides; one output register stage.

Parameters:
- ADDR_W, 10: width of the instruction-memory word address.
- BASE_ADDR, 0: address loaded on reset and on addr_clear.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input field tuple is valid.
- in_ready  out  1  encoder can accept a tuple.
- imm_src  in  2  format select: 00 I, 01 S, 10 B, 11 illegal.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- rd  in  5  destination register; used by I only.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2; used by S and B only.
- imm  in  32  signed immediate or byte offset.
- addr_clear  in  1  synchronous reset of the address counter to BASE_ADDR.
- out_valid  out  1  out_instr is valid.
- out_ready  in  1  downstream accepts the output.
- out_instr  out  32  encoded instruction.
- out_err  out  1  the tuple failed its range or format check.
- out_addr  out  ADDR_W  word address for out_instr.
- err_count  out  8  saturating count of errored outputs delivered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_instr=0, out_err=0.
  - out_addr=BASE_ADDR, err_count=0.
  - Reset mid-transfer drops the held word. No partial state survives.
- in_ready = !out_valid || out_ready. This is combinational; it does not register the ready path.
- Accept occurs when in_valid && in_ready. On the next edge the encoded word loads into the output register and out_valid=1. Latency is 1 cycle.
- Full-throughput streaming of 1 word/cycle is required while out_ready=1.
- While out_valid && !out_ready:
  - out_instr, out_err and out_addr hold stable.
  - No new accept occurs.
- Transfer occurs when out_valid && out_ready. If no accept happens in the same cycle, out_valid goes to 0.
- On each transfer:
  - out_addr increments by 1, wrapping modulo 2^ADDR_W.
  - If out_err=1, err_count increments and saturates at 255.
- Address and error updates apply on transfer, never on accept.
- addr_clear:
  - Sets out_addr to BASE_ADDR on the next edge.
  - If asserted in the same cycle as a transfer, addr_clear wins; the result is BASE_ADDR, not BASE_ADDR+1.
  - Does not affect err_count.
- Encoding:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Error checks:
  - I and S: imm must lie in [-2048, 2047], i.e. imm[31:11] all equal.
  - B: imm must lie in [-4096, 4094], i.e. imm[31:12] all equal, and imm[0] must be 0.
  - imm_src=11 is always an error.
  - On any error: out_instr=32'h0000_0013 (addi x0,x0,0), out_err=1.
- The error word still consumes an address slot.
- Unused fields (rd for S/B, rs2 for I) are ignored and have no effect on out_instr.

Test Plan:
- Reset, then I: rd=1, rs1=0, funct3=000, opcode=0010011, imm=5 → 1 cycle later out_valid=1, out_instr=0x00500093, out_err=0, out_addr=0; out_addr=1 after transfer.
- S: rs1=1, rs2=2, funct3=010, opcode=0100011, imm=8 → out_instr=0x0020A423.
- B: rs1=0, rs2=0, funct3=000, opcode=1100011, imm=-4 → out_instr=0xFE000EE3; B with imm=4094 → out_err=0, imm[12]=0, all other imm bits 1.
- Errors, in sequence:
  - I imm=2048
  - I imm=-2049
  - B imm=3
  - B imm=4096
  - imm_src=11
  - Required response for each: out_instr=0x00000013, out_err=1.
  - After all transfer: err_count=5 and out_addr has advanced by 5.
- Backpressure:
  - Stream 4 tuples back-to-back with out_ready=1 → 4 transfers in 4 cycles, addresses 0..3.
  - Then drop out_ready for 3 cycles with in_valid=1 → in_ready=0, output held stable, no address change.
  - Then raise out_ready → stream resumes with no loss or duplication.
- Boundaries and resets:
  - ADDR_W=2 → 5 transfers give addresses 0,1,2,3,0.
  - addr_clear together with a transfer → next out_addr=BASE_ADDR.
  - 300 error transfers → err_count=255.
  - rst_n low mid-backpressure → out_valid=0 immediately, without waiting for a clock edge.
